debounce_edge_gen: RTL and testbench

- Conditions a raw, asynchronous, bouncy input (push-button or switch) into a clean, synchronised level.
- Also produces single-cycle rise and fall pulses.
- Sits directly upstream of the D/T flip-flop stage and drives its d (or t) input and clock-enable logic.
- Combines a 2-FF synchroniser with a counter-qualified 4-state debounce FSM.

---
 rtl/debounce_edge_gen_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/debounce_edge_gen.sv | 130 +++++++++++++
 tb/tb_debounce_edge_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_edge_gen_pkg.sv
// -----------------------------------------------------------------------------
// debounce_edge_gen_pkg
// Shared definitions for the debounce / edge-generator block:
//   - state_e            : debounce FSM state encoding
//   - DEFAULT_STABLE_CNT : default number of qualifying ticks before db_out moves
// -----------------------------------------------------------------------------
package debounce_edge_gen_pkg;

  // Bit 1 of the encoding equals the debounced level; bit 0 xor bit 1 marks a
  // WAIT state. The FSM still registers its outputs explicitly.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_e;

  localparam int unsigned DEFAULT_STABLE_CNT = 4;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous bit. Output lags the input
// by two clk edges. Synchronous active-high reset clears both flops to 0.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   async_in in  asynchronous input bit
//   sync_out out synchronised bit (second flop)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic r_sync1;
  logic r_sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
    end
  end

  assign sync_out = r_sync2;

endmodule

// File: rtl/debounce_edge_gen.sv
// -----------------------------------------------------------------------------
// debounce_edge_gen
// Turns a raw, bouncy, asynchronous input into a clean synchronised level plus
// single-cycle rise/fall pulses. A 2-FF synchroniser feeds a 4-state FSM whose
// WAIT states require STABLE_CNT qualifying ticks at the new level.
// Parameters:
//   STABLE_CNT  qualifying ticks needed to accept a new level (1..65535)
//   CNT_W       stability counter width, 2**CNT_W > STABLE_CNT
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   raw_in     in  asynchronous bouncy input
//   tick       in  counter advance strobe (tie high to count every cycle)
//   db_out     out debounced level
//   rise_pulse out one-cycle pulse on db_out 0->1
//   fall_pulse out one-cycle pulse on db_out 1->0
//   busy       out high while in WAIT_HIGH or WAIT_LOW
// -----------------------------------------------------------------------------
module debounce_edge_gen
  import debounce_edge_gen_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic tick,
  output logic db_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             w_sync;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db_out;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;

  sync_2ff u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (raw_in),
    .sync_out (w_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE_LOW;
      r_cnt    <= '0;
      r_db_out <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_sync) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A reversal aborts before any completion check: no partial credit.
          if (!w_sync) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (tick) begin
            if (r_cnt == CNT_LAST) begin
              r_state  <= IDLE_HIGH;
              r_cnt    <= '0;
              r_busy   <= 1'b0;
              r_db_out <= 1'b1;
              r_rise   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        IDLE_HIGH: begin
          if (!w_sync) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (w_sync) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (tick) begin
            if (r_cnt == CNT_LAST) begin
              r_state  <= IDLE_LOW;
              r_cnt    <= '0;
              r_busy   <= 1'b0;
              r_db_out <= 1'b0;
              r_fall   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          r_state  <= IDLE_LOW;
          r_cnt    <= '0;
          r_busy   <= 1'b0;
          r_db_out <= 1'b0;
        end
      endcase
    end
  end

  assign db_out     = r_db_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;

endmodule

// File: tb/tb_debounce_edge_gen.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge_gen
// Two instances share stimulus: STABLE_CNT=4 (default) and STABLE_CNT=1.
// A reference model predicts {db_out, rise_pulse, fall_pulse, busy} at every
// edge and queues it; a monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_debounce_edge_gen;

  logic clk = 1'b0;
  logic rst;
  logic raw_in;
  logic tick;

  logic db4, rise4, fall4, busy4;
  logic db1, rise1, fall1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_edge_gen #(.STABLE_CNT(4), .CNT_W(16)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .tick       (tick),
    .db_out     (db4),
    .rise_pulse (rise4),
    .fall_pulse (fall4),
    .busy       (busy4)
  );

  debounce_edge_gen #(.STABLE_CNT(1), .CNT_W(4)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .tick       (tick),
    .db_out     (db1),
    .rise_pulse (rise1),
    .fall_pulse (fall1),
    .busy       (busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the input reaches the decision logic two edges late. While
  // the delayed input disagrees with the accepted level, a run is in progress;
  // the first disagreeing edge opens the run, each later edge with tick counts
  // one, and the run is accepted when the count reaches `stable`. Agreement at
  // any edge cancels the run.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit s1, s2;
    bit level;
    bit in_run;
    int run_ticks;
    bit rise, fall;
  } model_t;

  function automatic model_t model_step(model_t m, bit r, bit raw, bit tk, int stable);
    model_t n = m;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (m.s2 == m.level) begin
      n.in_run = 1'b0;
    end else if (!m.in_run) begin
      n.in_run    = 1'b1;
      n.run_ticks = 0;
    end else if (tk) begin
      n.run_ticks = m.run_ticks + 1;
      if (n.run_ticks == stable) begin
        n.level  = m.s2;
        n.in_run = 1'b0;
        n.rise   = m.s2;
        n.fall   = !m.s2;
      end
    end
    n.s2 = m.s1;
    n.s1 = raw;
    return n;
  endfunction

  function automatic logic [3:0] model_out(model_t m);
    return {m.level, m.rise, m.fall, m.in_run};
  endfunction

  model_t m4 = '{default: 0};
  model_t m1 = '{default: 0};
  logic [3:0] q4[$];
  logic [3:0] q1[$];

  // Scoreboard producer: predicts the response to the inputs sampled this edge.
  always @(posedge clk) begin
    m4 = model_step(m4, rst, raw_in, tick, 4);
    m1 = model_step(m1, rst, raw_in, tick, 1);
    q4.push_back(model_out(m4));
    q1.push_back(model_out(m1));
  end

  // Scoreboard consumer: compares every cycle's outputs, away from the edge.
  initial begin
    logic [3:0] e4, e1;
    forever begin
      @(posedge clk);
      #1;
      e4 = (q4.size() > 0) ? q4.pop_front() : 4'bxxxx;
      e1 = (q1.size() > 0) ? q1.pop_front() : 4'bxxxx;
      check("sb_cnt4", {28'd0, db4, rise4, fall4, busy4}, {28'd0, e4});
      check("sb_cnt1", {28'd0, db1, rise1, fall1, busy1}, {28'd0, e1});
      check("pulse_excl4", {31'd0, rise4 & fall4}, 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed check of the STABLE_CNT=4 instance, sampled at a negedge.
  task automatic chk4(input string name, input logic db, input logic ri, input logic fa, input logic bu);
    check(name, {28'd0, db4, rise4, fall4, busy4}, {28'd0, db, ri, fa, bu});
  endtask

  initial begin
    int ticks_issued;
    int fall_seen;
    bit done;

    rst    = 1'b1;
    raw_in = 1'b1;
    tick   = 1'b1;

    // 1. Reset dominates a high raw input; release then rise at edge 6.
    cyc(1); chk4("rst_cyc0", 0, 0, 0, 0);
    cyc(1); chk4("rst_cyc1", 0, 0, 0, 0);
    rst = 1'b0;
    cyc(6); chk4("rel_edge5", 0, 0, 0, 1);
    cyc(1); chk4("rel_edge6_rise", 1, 1, 0, 0);

    // 2. Pulse lasts one cycle; clean fall 6 edges after raw drops.
    cyc(1); chk4("rise_one_cycle", 1, 0, 0, 0);
    raw_in = 1'b0;
    cyc(6); chk4("fall_edge5", 1, 0, 0, 1);
    cyc(1); chk4("fall_edge6", 0, 0, 1, 0);
    fall_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      fall_seen += int'(fall4);
    end
    check("fall_once", fall_seen, 0);

    // 3. Bounce: 2-cycle toggles never qualify; settle rises 6 edges later.
    for (int p = 0; p < 4; p++) begin
      raw_in = (p % 2 == 0);
      for (int i = 0; i < 2; i++) begin
        cyc(1);
        check("bounce_no_rise", {30'd0, db4, rise4}, 32'd0);
      end
    end
    raw_in = 1'b1;
    cyc(6); chk4("settle_edge5", 0, 0, 0, 1);
    cyc(1); chk4("settle_edge6", 1, 1, 0, 0);

    // Return low before the abort test.
    raw_in = 1'b0;
    cyc(12); chk4("back_low", 0, 0, 0, 0);

    // 4. Late abort: four high samples reach cnt==3, and the reversal arrives
    // on the edge that would otherwise have completed.
    raw_in = 1'b1;
    cyc(4);
    raw_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("late_abort_no_rise", {30'd0, db4, rise4}, 32'd0);
    end
    chk4("late_abort_idle", 0, 0, 0, 0);

    // 5. Tick gating: no ticks keeps WAIT indefinitely; then one tick in four.
    tick   = 1'b0;
    raw_in = 1'b1;
    cyc(3);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("tick0_stays_wait", {30'd0, db4, busy4}, 32'd1);
    end
    ticks_issued = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick = (i % 4 == 0);
      ticks_issued += int'(tick);
      cyc(1);
      if (db4) done = 1'b1;
    end
    check("tick_gate_done", {31'd0, done}, 32'd1);
    check("tick_gate_count", ticks_issued, 4);
    tick = 1'b1;

    // 6. Mid-operation reset forces db_out low with no fall pulse.
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (db4) done = 1'b1;
      else cyc(1);
    end
    check("pre_rst_high", {31'd0, done}, 32'd1);
    rst = 1'b1;
    cyc(1); chk4("mid_rst", 0, 0, 0, 0);
    rst = 1'b0;
    cyc(6); chk4("rerise_edge5", 0, 0, 0, 1);
    cyc(1); chk4("rerise_edge6", 1, 1, 0, 0);

    // Randomised phase: runs of random length, random tick, rare resets.
    for (int c = 0; c < 450; c++) begin
      int len;
      len    = $urandom_range(1, 12);
      raw_in = 1'($urandom_range(0, 1));
      repeat (len) begin
        tick = ($urandom_range(0, 3) != 0);
        rst  = ($urandom_range(0, 149) == 0);
        cyc(1);
      end
    end
    rst  = 1'b0;
    tick = 1'b1;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
